// File: rtl/dff_usr_pkg.sv
// Shared mode encodings, per-bit mux selects and a whole-word next-state helper
// for the universal shift register family.
package dff_usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd6;

  localparam logic [1:0] SEL_SELF  = 2'd0;
  localparam logic [1:0] SEL_D     = 2'd1;
  localparam logic [1:0] SEL_LOWER = 2'd2;
  localparam logic [1:0] SEL_UPPER = 2'd3;

  localparam int USR_MAX_W = 64;

  // Word-level next state for any width up to USR_MAX_W; bits above width are zero.
  function automatic logic [USR_MAX_W-1:0] next_q(
    input logic [MODE_W-1:0]    mode,
    input logic [USR_MAX_W-1:0] q,
    input logic [USR_MAX_W-1:0] d,
    input logic                 serL,
    input logic                 serR,
    input logic [USR_MAX_W-1:0] rstVal,
    input int                   width
  );
    logic [USR_MAX_W-1:0] mask;
    logic [USR_MAX_W-1:0] qm;
    logic [USR_MAX_W-1:0] res;
    mask = (width >= USR_MAX_W) ? '1 : ((USR_MAX_W'(1) << width) - USR_MAX_W'(1));
    qm   = q & mask;
    case (mode)
      MODE_LOAD: res = d;
      MODE_SHL:  res = (qm << 1) | USR_MAX_W'(serL);
      MODE_SHR:  res = (qm >> 1) | (USR_MAX_W'(serR) << (width - 1));
      MODE_ROL:  res = (qm << 1) | USR_MAX_W'(qm[width-1]);
      MODE_ROR:  res = (qm >> 1) | (USR_MAX_W'(qm[0]) << (width - 1));
      MODE_CLR:  res = rstVal;
      default:   res = qm;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/dff_usr_cell.sv
// One bit slice of the universal register: a 4:1 next-value mux feeding a flop
// that shares enable and synchronous active-low reset with its neighbours.
module dff_usr_cell
  import dff_usr_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstN,
  input  logic       i_en,
  input  logic       i_rstVal,
  input  logic [1:0] i_sel,
  input  logic       i_d,
  input  logic       i_lower,
  input  logic       i_upper,
  output logic       o_q
);

  logic r_q;
  logic w_next;

  always_comb begin
    w_next = r_q;
    case (i_sel)
      SEL_D:     w_next = i_d;
      SEL_LOWER: w_next = i_lower;
      SEL_UPPER: w_next = i_upper;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_q <= i_rstVal;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_univ_shift_reg.sv
// WIDTH-bit universal register built from per-bit cells, with serial output and
// a saturating shift-occupancy counter.
module dff_univ_shift_reg
  import dff_usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 4
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              inEn,
  input  logic [MODE_W-1:0] inMode,
  input  logic [WIDTH-1:0]  inD,
  input  logic              inSerL,
  input  logic              inSerR,
  output logic [WIDTH-1:0]  outQ,
  output logic              outSerOut,
  output logic [CNT_W-1:0]  outCnt,
  output logic              outDrained
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_dSel;
  logic [1:0]       w_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_serOut;

  // CLR reuses the parallel-load path with the reset pattern as data.
  assign w_dSel = (inMode == MODE_CLR) ? RST_VAL : inD;

  always_comb begin
    w_sel = SEL_SELF;
    case (inMode)
      MODE_LOAD, MODE_CLR: w_sel = SEL_D;
      MODE_SHL,  MODE_ROL: w_sel = SEL_LOWER;
      MODE_SHR,  MODE_ROR: w_sel = SEL_UPPER;
      default:             w_sel = SEL_SELF;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_lower;
    logic w_upper;

    // End bits pick either the serial input or the wrap-around bit.
    if (i == 0) begin : g_lsb
      assign w_lower = (inMode == MODE_ROL) ? w_q[WIDTH-1] : inSerL;
    end else begin : g_lowMid
      assign w_lower = w_q[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign w_upper = (inMode == MODE_ROR) ? w_q[0] : inSerR;
    end else begin : g_upMid
      assign w_upper = w_q[i+1];
    end

    dff_usr_cell u_cell (
      .i_clk    (inClk),
      .i_rstN   (inRstN),
      .i_en     (inEn),
      .i_rstVal (RST_VAL[i]),
      .i_sel    (w_sel),
      .i_d      (w_dSel[i]),
      .i_lower  (w_lower),
      .i_upper  (w_upper),
      .o_q      (w_q[i])
    );
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      r_cnt    <= '0;
      r_serOut <= 1'b0;
    end else if (inEn) begin
      r_serOut <= 1'b0;
      case (inMode)
        MODE_LOAD, MODE_CLR: r_cnt <= '0;
        MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: begin
          if (r_cnt != CNT_FULL) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (inMode == MODE_SHL) begin
            r_serOut <= w_q[WIDTH-1];
          end else if (inMode == MODE_SHR) begin
            r_serOut <= w_q[0];
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign outQ       = w_q;
  assign outSerOut  = r_serOut;
  assign outCnt     = r_cnt;
  assign outDrained = (r_cnt == CNT_FULL);

endmodule
